// File: rtl/fir_pkg.sv
// Shared sizing helpers and constants for the programmable FIR filter.
package fir_pkg;

    // Full-precision width of one coefficient * sample product.
    function automatic int prod_width(input int data_w, input int coeff_w);
        return data_w + coeff_w;
    endfunction

    // Accumulator width: product width plus enough guard bits for TAPS terms.
    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    // Largest representable signed output value.
    function automatic longint sat_max(input int data_w);
        return (64'sd1 <<< (data_w - 1)) - 64'sd1;
    endfunction

    // Most negative representable signed output value.
    function automatic longint sat_min(input int data_w);
        return -(64'sd1 <<< (data_w - 1));
    endfunction

    // Coefficient value representing 1.0 with the given fractional bits.
    function automatic longint coef_identity(input int frac_bits);
        return 64'sd1 <<< frac_bits;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and output saturation.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_WIDTH  = 35,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 14
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         sat
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam int EW = ACC_WIDTH + 1;
    localparam int RW = EW - FRAC_BITS;

    localparam logic signed [EW-1:0]         HALF  = EW'(64'sd1 <<< (FRAC_BITS - 1));
    localparam longint                       YMAX  = sat_max(DATA_WIDTH);
    localparam longint                       YMIN  = sat_min(DATA_WIDTH);
    localparam logic signed [DATA_WIDTH-1:0] YMAXW = DATA_WIDTH'(YMAX);
    localparam logic signed [DATA_WIDTH-1:0] YMINW = DATA_WIDTH'(YMIN);

    // Add one half LSB of the result, then floor-shift: ties go toward +inf.
    function automatic logic signed [RW-1:0] round_shr(input logic signed [ACC_WIDTH-1:0] a);
        return RW'((EW'(a) + HALF) >>> FRAC_BITS);
    endfunction

    // Clip to the output range; the top bit of the result flags clipping.
    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [RW-1:0] r);
        longint rv;
        rv = longint'(r);
        if (rv > YMAX) begin
            return {1'b1, YMAXW};
        end else if (rv < YMIN) begin
            return {1'b1, YMINW};
        end
        return {1'b0, r[DATA_WIDTH-1:0]};
    endfunction

    // Scale and clip the accumulator into an output sample.
    always_comb begin
        {sat, y} = saturate(round_shr(acc));
    end

endmodule

// File: rtl/fir_filter_prog.sv
// Programmable-coefficient FIR: valid-gated delay line, registered products,
// registered rounded/saturated sum, with a valid bit following each stage.
module fir_filter_prog
    import fir_pkg::*;
#(
    parameter int TAPS        = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int FRAC_BITS   = 14
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    input  logic signed [DATA_WIDTH-1:0]   x_in,
    input  logic                           coef_we,
    input  logic [$clog2(TAPS)-1:0]        coef_addr,
    input  logic signed [COEFF_WIDTH-1:0]  coef_data,
    output logic                           out_valid,
    output logic signed [DATA_WIDTH-1:0]   y_out,
    output logic                           sat
);

    localparam int PW = prod_width(DATA_WIDTH, COEFF_WIDTH);
    localparam int AW = acc_width(DATA_WIDTH, COEFF_WIDTH, TAPS);
    localparam logic signed [COEFF_WIDTH-1:0] COEF_ONE = COEFF_WIDTH'(coef_identity(FRAC_BITS));

    logic signed [DATA_WIDTH-1:0]  x_p0_q     [TAPS];
    logic                          vld_p0_q;
    logic signed [COEFF_WIDTH-1:0] coeff_q    [TAPS];
    logic signed [PW-1:0]          prod_p1_q  [TAPS];
    logic                          vld_p1_q;
    logic signed [AW-1:0]          acc_d;
    logic signed [DATA_WIDTH-1:0]  y_d;
    logic                          sat_d;
    logic signed [DATA_WIDTH-1:0]  y_p2_q;
    logic                          sat_p2_q;
    logic                          vld_p2_q;
    logic                          addr_ok;

    // Writes to non-existent taps are dropped.
    assign addr_ok = (32'(coef_addr) < TAPS);

    // Stage 0: delay line shifts only when a new sample is offered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) x_p0_q[k] <= '0;
            vld_p0_q <= 1'b0;
        end else begin
            vld_p0_q <= in_valid;
            if (in_valid) begin
                x_p0_q[0] <= x_in;
                for (int k = 1; k < TAPS; k++) x_p0_q[k] <= x_p0_q[k-1];
            end
        end
    end

    // Coefficient bank; reset loads a unit impulse response (pass-through).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) coeff_q[k] <= (k == 0) ? COEF_ONE : '0;
        end else if (coef_we && addr_ok) begin
            coeff_q[coef_addr] <= coef_data;
        end
    end

    // Stage 1: full-precision per-tap products.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) prod_p1_q[k] <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            for (int k = 0; k < TAPS; k++) prod_p1_q[k] <= PW'(coeff_q[k]) * PW'(x_p0_q[k]);
            vld_p1_q <= vld_p0_q;
        end
    end

    // Sum of the sign-extended products; guard bits make overflow impossible.
    always_comb begin
        acc_d = '0;
        for (int k = 0; k < TAPS; k++) acc_d = acc_d + AW'(prod_p1_q[k]);
    end

    fir_round_sat #(
        .ACC_WIDTH  (AW),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_round_sat (
        .acc (acc_d),
        .y   (y_d),
        .sat (sat_d)
    );

    // Stage 2: output registers update only for valid samples, else hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2_q <= 1'b0;
            y_p2_q   <= '0;
            sat_p2_q <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                y_p2_q   <= y_d;
                sat_p2_q <= sat_d;
            end
        end
    end

    assign out_valid = vld_p2_q;
    assign y_out     = y_p2_q;
    assign sat       = sat_p2_q;

endmodule
